pipe_elastic_stage: RTL and testbench



---
 rtl/pipe_elastic_stage.sv | 91 +++++++++
 tb/tb_pipe_elastic_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage: valid/ready pipeline register with a 2-entry skid buffer and synchronous flush.
// Upstream ready and downstream valid are decoded from state only, so back-pressure never reaches in_ready combinationally.
module pipe_elastic_stage #(
   parameter int                DATA_W      = 32,
   parameter int                CTRL_W      = 12,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t            state, state_nx;
   logic [DATA_W-1:0] m_data, m_data_nx, s_data, s_data_nx;
   logic [CTRL_W-1:0] m_ctrl, m_ctrl_nx, s_ctrl, s_ctrl_nx;
   logic              acc, dep;
   assign in_ready  = state != TWO;
   assign out_valid = state != EMPTY;
   assign occupancy = state;
   assign out_data  = m_data;
   assign out_ctrl  = m_ctrl;
   assign acc       = in_valid & in_ready;
   assign dep       = out_valid & out_ready;
   // m_ctrl is rewritten to the bubble on every path into EMPTY, keeping out_ctrl a pure flop output
   always_comb begin
      state_nx  = state;
      m_data_nx = m_data;
      m_ctrl_nx = m_ctrl;
      s_data_nx = s_data;
      s_ctrl_nx = s_ctrl;
      if (flush) begin
         state_nx  = EMPTY;
         m_ctrl_nx = BUBBLE_CTRL;
         s_ctrl_nx = BUBBLE_CTRL;
      end else begin
         case (state)
            EMPTY: if (acc) begin
               m_data_nx = in_data;
               m_ctrl_nx = in_ctrl;
               state_nx  = ONE;
            end
            ONE: if (acc && dep) begin
               m_data_nx = in_data;
               m_ctrl_nx = in_ctrl;
            end else if (acc) begin
               s_data_nx = in_data;
               s_ctrl_nx = in_ctrl;
               state_nx  = TWO;
            end else if (dep) begin
               m_ctrl_nx = BUBBLE_CTRL;
               state_nx  = EMPTY;
            end
            TWO: if (dep) begin
               m_data_nx = s_data;
               m_ctrl_nx = s_ctrl;
               s_ctrl_nx = BUBBLE_CTRL;
               state_nx  = ONE;
            end
            default: begin
               state_nx  = EMPTY;
               m_ctrl_nx = BUBBLE_CTRL;
               s_ctrl_nx = BUBBLE_CTRL;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state  <= EMPTY;
         m_data <= '0;
         m_ctrl <= BUBBLE_CTRL;
         s_data <= '0;
         s_ctrl <= BUBBLE_CTRL;
      end else begin
         state  <= state_nx;
         m_data <= m_data_nx;
         m_ctrl <= m_ctrl_nx;
         s_data <= s_data_nx;
         s_ctrl <= s_ctrl_nx;
      end
   end
endmodule

// File: tb/tb_pipe_elastic_stage.sv
// tb_pipe_elastic_stage: directed checks of pipe_elastic_stage plus a randomized run against a 2-deep FIFO model.
module tb_pipe_elastic_stage;
   localparam int             DW  = 32;
   localparam int             CW  = 12;
   localparam logic [CW-1:0]  BUB = 12'h800;
   logic          clk = 1'b0, clrn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          in_ready, out_valid, in_ready0, out_valid0;
   logic [DW-1:0] out_data, out_data0;
   logic [CW-1:0] out_ctrl, out_ctrl0;
   logic [1:0]    occupancy, occupancy0;
   int            checks = 0, failures = 0;
   always #5 clk = ~clk;
   pipe_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB)) dut (
      .clk(clk), .clrn(clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy));
   pipe_elastic_stage #(.DATA_W(DW), .CTRL_W(CW)) dut0 (
      .clk(clk), .clrn(clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occupancy0));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = r;
      flush     = f;
   endtask
   initial begin
      logic [DW+CW-1:0] q[$];
      logic [DW+CW-1:0] h;
      logic             acc_m, dep_m;
      #12;
      chk("rst_occ", occupancy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_data", out_data, 0);
      chk("rst_ctrl", out_ctrl, BUB);
      chk("rst_ctrl0", out_ctrl0, 0);
      clrn = 1'b1;
      tick();
      // fill to TWO, then reset asynchronously between edges
      drive(1, 32'h11, 12'h3, 0, 0);
      tick();
      chk("fill_a_data", out_data, 32'h11);
      chk("fill_a_ctrl", out_ctrl, 12'h3);
      drive(1, 32'h22, 12'h5, 0, 0);
      tick();
      chk("fill_occ2", occupancy, 2);
      chk("fill_ready0", in_ready, 0);
      chk("fill_hold_a", out_data, 32'h11);
      in_valid = 1'b0;
      #3 clrn = 1'b0;
      #1;
      chk("arst_occ", occupancy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_data", out_data, 0);
      chk("arst_ctrl", out_ctrl, BUB);
      chk("arst_occ0", occupancy0, 0);
      chk("arst_ready0", in_ready0, 1);
      #2 clrn = 1'b1;
      tick();
      // streaming at full throughput
      for (int i = 0; i < 16; i++) begin
         drive(1, 32'h100 + i, CW'(i), 1, 0);
         tick();
         chk("stream_data", out_data, 32'h100 + i);
         chk("stream_ctrl", out_ctrl, i);
         chk("stream_occ", occupancy, 1);
      end
      drive(0, 0, 0, 1, 0);
      tick();
      chk("stream_end_valid", out_valid, 0);
      chk("stream_end_ctrl", out_ctrl, BUB);
      // back-pressure
      drive(1, 32'hA, 12'h1, 0, 0);
      tick();
      drive(1, 32'hB, 12'h2, 0, 0);
      tick();
      chk("bp_occ2", occupancy, 2);
      chk("bp_ready0", in_ready, 0);
      chk("bp_data_a", out_data, 32'hA);
      drive(1, 32'hC, 12'h3, 0, 0);
      tick();
      chk("bp_stall_data", out_data, 32'hA);
      chk("bp_stall_ctrl", out_ctrl, 12'h1);
      chk("bp_stall_occ", occupancy, 2);
      out_ready = 1'b1;
      tick();
      chk("bp_data_b", out_data, 32'hB);
      chk("bp_occ1", occupancy, 1);
      chk("bp_ready1", in_ready, 1);
      tick();
      chk("bp_data_c", out_data, 32'hC);
      chk("bp_ctrl_c", out_ctrl, 12'h3);
      in_valid = 1'b0;
      tick();
      chk("bp_drained", out_valid, 0);
      // flush in TWO with a simultaneous accept and depart
      drive(1, 32'h31, 12'h1, 0, 0);
      tick();
      drive(1, 32'h32, 12'h2, 0, 0);
      tick();
      chk("fl_occ2", occupancy, 2);
      drive(1, 32'h33, 12'h4, 1, 1);
      tick();
      chk("fl_occ", occupancy, 0);
      chk("fl_valid", out_valid, 0);
      chk("fl_ctrl", out_ctrl, BUB);
      chk("fl_ready", in_ready, 1);
      drive(1, 32'h55, 12'h7, 0, 0);
      tick();
      chk("fl_next_data", out_data, 32'h55);
      chk("fl_next_ctrl", out_ctrl, 12'h7);
      chk("fl_next_occ", occupancy, 1);
      drive(0, 0, 0, 1, 0);
      tick();
      chk("fl_alone", occupancy, 0);
      // drain to bubble with both bubble values
      drive(1, 32'h77, 12'hFFF, 0, 0);
      tick();
      chk("drn_ctrl", out_ctrl, 12'hFFF);
      chk("drn_ctrl0", out_ctrl0, 12'hFFF);
      chk("drn_data0", out_data0, 32'h77);
      drive(0, 0, 0, 1, 0);
      tick();
      chk("drn_valid", out_valid, 0);
      chk("drn_bub", out_ctrl, BUB);
      chk("drn_valid0", out_valid0, 0);
      chk("drn_bub0", out_ctrl0, 0);
      // random traffic against a FIFO model
      for (int i = 0; i < 10000; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, CW'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 99) < 2);
         chk("rnd_occ", occupancy, q.size());
         chk("rnd_ready", in_ready, q.size() != 2);
         if (q.size() != 0) begin
            h = q[0];
            chk("rnd_head", {out_data, out_ctrl}, h);
         end else begin
            chk("rnd_bub", out_ctrl, BUB);
         end
         acc_m = in_valid && q.size() != 2;
         dep_m = out_ready && q.size() != 0;
         if (flush) q.delete();
         else begin
            if (dep_m) void'(q.pop_front());
            if (acc_m) q.push_back({in_data, in_ctrl});
         end
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
